text_line_sequencer: RTL and testbench

Sequences the shared 8x8 glyph ROM for one on-screen text field, such as the BET or PAYOUT readouts. During horizontal blanking it fetches the current glyph row of every character in a small string register into a line buffer. During the active line it serialises those pixels on demand from the VGA pixel pipeline. It sits between the game/score logic (string writes), the VGA timing generator (line_start, y_row, pix_advance) and the glyph ROM (1-cycle registered read, address = ascii*8 + row).

---
 rtl/text_line_sequencer_pkg.sv | 14 +
 rtl/text_line_sequencer_glyph_serializer.sv | 71 +++++++
 rtl/text_line_sequencer.sv | 147 ++++++++++++++
 tb/tb_text_line_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/text_line_sequencer_pkg.sv
// Shared constants for the text-field glyph sequencer.
package text_line_sequencer_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    localparam int unsigned GLYPH_W     = 8;
    localparam int unsigned GLYPH_H     = 8;
    localparam logic [7:0]  BLANK_CHAR  = 8'h20;
    localparam int unsigned ROM_LATENCY = 1;

endpackage

// File: rtl/text_line_sequencer_glyph_serializer.sv
// Line buffer plus the sub-pixel/column/char walk that drives pix_on.
module glyph_serializer
    import text_line_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CHARS = 8,
    parameter int unsigned SCALE     = 1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           cap_en,
    input  logic [((NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1)-1:0] cap_idx,
    input  logic [GLYPH_W-1:0]                             cap_data,
    input  logic                                           restart,
    input  logic                                           advance,
    input  logic                                           hold,
    output logic                                           pix_on,
    output logic                                           last_pos_c
);

    localparam int unsigned IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    logic [GLYPH_W-1:0] line_buf [NUM_CHARS];
    logic [SUB_W-1:0]   sub;
    logic [2:0]         col;
    logic [IDX_W-1:0]   chr;

    // Final sub-pixel of the final column of the final character.
    assign last_pos_c = (sub == SUB_W'(SCALE - 1)) && (col == 3'(GLYPH_W - 1)) &&
                        (chr == IDX_W'(NUM_CHARS - 1));

    // Capture fetched glyph rows.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHARS; i++) line_buf[i] <= '0;
        end else if (cap_en) begin
            line_buf[cap_idx] <= cap_data;
        end
    end

    // Walk sub-pixel, column and character on each consumed pixel.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            sub <= '0;
            col <= '0;
            chr <= '0;
        end else if (advance) begin
            if (sub == SUB_W'(SCALE - 1)) begin
                sub <= '0;
                col <= col + 3'd1;
                if (col == 3'(GLYPH_W - 1)) begin
                    chr <= (chr == IDX_W'(NUM_CHARS - 1)) ? '0 : chr + IDX_W'(1);
                end
            end else begin
                sub <= sub + SUB_W'(1);
            end
        end
    end

    // Pixel output: new bit on advance, held during the line, zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_on <= 1'b0;
        end else if (advance) begin
            pix_on <= line_buf[chr][3'(GLYPH_W - 1) - col];
        end else if (!hold) begin
            pix_on <= 1'b0;
        end
    end

endmodule

// File: rtl/text_line_sequencer.sv
// Fetches one glyph row per character during hblank, then serialises it.
module text_line_sequencer
    import text_line_sequencer_pkg::*;
#(
    parameter int unsigned NUM_CHARS = 8,
    parameter int unsigned SCALE     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       char_wr_en,
    input  logic [3:0] char_wr_addr,
    input  logic [7:0] char_wr_data,
    input  logic       line_start,
    input  logic [3:0] y_row,
    input  logic       active_line,
    input  logic       pix_advance,
    output logic       pix_on,
    output logic [7:0] rom_ascii,
    output logic [3:0] rom_row,
    input  logic [7:0] rom_pixels,
    output logic       busy,
    output logic       underrun
);

    localparam int unsigned IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CHARS + ROM_LATENCY + 1);

    logic [7:0]       str [NUM_CHARS];
    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] fcnt, fcnt_n;
    logic             blank, blank_n;
    logic [7:0]       rom_ascii_n;
    logic [3:0]       rom_row_n;
    logic             underrun_n;
    logic             cap_en_c;
    logic [IDX_W-1:0] cap_idx_c;
    logic [7:0]       cap_data_c;
    logic             advance_c;
    logic             hold_c;
    logic             last_pos_c;

    // String register; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHARS; i++) str[i] <= BLANK_CHAR;
        end else if (char_wr_en && ({1'b0, char_wr_addr} < 5'(NUM_CHARS))) begin
            str[char_wr_addr[IDX_W-1:0]] <= char_wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Next state, ROM issue, capture and serializer control.
    always_comb begin
        state_n     = state;
        fcnt_n      = fcnt;
        blank_n     = blank;
        rom_ascii_n = rom_ascii;
        rom_row_n   = rom_row;
        underrun_n  = underrun;
        cap_en_c    = 1'b0;
        cap_idx_c   = '0;
        cap_data_c  = rom_pixels;
        advance_c   = 1'b0;
        hold_c      = 1'b0;

        if (line_start) begin
            // A new line always aborts whatever is in flight.
            if (active_line) begin
                state_n = ST_FETCH;
                fcnt_n  = '0;
                blank_n = y_row[3];
                if (!y_row[3]) begin
                    rom_ascii_n = str[0];
                    rom_row_n   = {1'b0, y_row[2:0]};
                end
            end else begin
                state_n = ST_IDLE;
            end
        end else begin
            case (state)
                ST_IDLE: ;
                ST_FETCH: begin
                    if (pix_advance) underrun_n = 1'b1;
                    fcnt_n = fcnt + CNT_W'(1);
                    if (fcnt >= CNT_W'(ROM_LATENCY)) begin
                        cap_en_c   = 1'b1;
                        cap_idx_c  = IDX_W'(fcnt - CNT_W'(ROM_LATENCY));
                        cap_data_c = blank ? 8'h00 : rom_pixels;
                    end
                    if (!blank && (fcnt < CNT_W'(NUM_CHARS - 1))) begin
                        rom_ascii_n = str[IDX_W'(fcnt + CNT_W'(1))];
                    end
                    if (fcnt == CNT_W'(NUM_CHARS + ROM_LATENCY - 1)) begin
                        state_n = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    advance_c = pix_advance;
                    hold_c    = 1'b1;
                    if (pix_advance && last_pos_c) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt      <= '0;
            blank     <= 1'b0;
            busy      <= 1'b0;
            rom_ascii <= BLANK_CHAR;
            rom_row   <= 4'd0;
            underrun  <= 1'b0;
        end else begin
            fcnt      <= fcnt_n;
            blank     <= blank_n;
            busy      <= (state_n == ST_FETCH);
            rom_ascii <= rom_ascii_n;
            rom_row   <= rom_row_n;
            underrun  <= underrun_n;
        end
    end

    glyph_serializer #(
        .NUM_CHARS (NUM_CHARS),
        .SCALE     (SCALE)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .cap_en     (cap_en_c),
        .cap_idx    (cap_idx_c),
        .cap_data   (cap_data_c),
        .restart    (line_start),
        .advance    (advance_c),
        .hold       (hold_c),
        .pix_on     (pix_on),
        .last_pos_c (last_pos_c)
    );

endmodule

// File: tb/tb_text_line_sequencer.sv
// Directed bench: two instances (8 chars x1, 2 chars x2) sharing stimulus.
module tb_text_line_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       char_wr_en = 1'b0;
    logic [3:0] char_wr_addr = '0;
    logic [7:0] char_wr_data = '0;
    logic       line_start = 1'b0;
    logic [3:0] y_row = '0;
    logic       active_line = 1'b0;
    logic       pix_advance = 1'b0;

    logic       pix1, pix2, busy1, busy2, und1, und2;
    logic [7:0] asc1, asc2, px1, px2;
    logic [3:0] row1, row2;

    int tests = 0;
    int failed = 0;
    logic [7:0] s1 [8];

    always #5 clk = ~clk;

    text_line_sequencer #(.NUM_CHARS(8), .SCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .char_wr_en(char_wr_en), .char_wr_addr(char_wr_addr),
        .char_wr_data(char_wr_data), .line_start(line_start), .y_row(y_row),
        .active_line(active_line), .pix_advance(pix_advance), .pix_on(pix1),
        .rom_ascii(asc1), .rom_row(row1), .rom_pixels(px1), .busy(busy1), .underrun(und1));

    text_line_sequencer #(.NUM_CHARS(2), .SCALE(2)) u_dut2 (
        .clk(clk), .reset(reset), .char_wr_en(char_wr_en), .char_wr_addr(char_wr_addr),
        .char_wr_data(char_wr_data), .line_start(line_start), .y_row(y_row),
        .active_line(active_line), .pix_advance(pix_advance), .pix_on(pix2),
        .rom_ascii(asc2), .rom_row(row2), .rom_pixels(px2), .busy(busy2), .underrun(und2));

    function automatic logic [7:0] glyph(input logic [7:0] a, input logic [2:0] r);
        logic [63:0] f;
        case (a)
            8'h42:   f = 64'hFC66_667C_6666_FC00;
            8'h45:   f = 64'hFE62_6878_6862_FE00;
            8'h54:   f = 64'hFCB4_3030_3030_7800;
            8'h31:   f = 64'h3070_3030_3030_FC00;
            default: f = 64'h0;
        endcase
        return f[8*(7-int'(r)) +: 8];
    endfunction

    function automatic logic pix_exp(input logic [7:0] a, input logic [2:0] r, input int c);
        logic [7:0] g;
        g = glyph(a, r);
        return g[7-c];
    endfunction

    // Registered glyph ROMs, one per instance.
    always @(posedge clk) begin
        px1 <= glyph(asc1, row1[2:0]);
        px2 <= glyph(asc2, row2[2:0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        char_wr_en = 1'b1; char_wr_addr = a; char_wr_data = d;
        step();
        char_wr_en = 1'b0;
        if (a < 4'd8) s1[a[2:0]] = d;
    endtask

    task automatic start_line(input logic [3:0] r, input logic act);
        line_start = 1'b1; y_row = r; active_line = act;
        step();
        line_start = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_asc [8];
        for (int i = 0; i < 8; i++) s1[i] = 8'h20;
        exp_asc[0] = 8'h42; exp_asc[1] = 8'h45; exp_asc[2] = 8'h54;
        for (int i = 3; i < 8; i++) exp_asc[i] = 8'h20;

        // Reset values
        step(); step();
        chk("rst_pix", 32'(pix1), 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_und", 32'(und1), 32'h0);
        chk("rst_ascii", 32'(asc1), 32'h20);
        chk("rst_row", 32'(row1), 32'h0);
        reset = 1'b0;
        step();

        // Test 1: fetch of "BET     " row 0; index 8 write must be ignored
        wr(4'd0, 8'h42); wr(4'd1, 8'h45); wr(4'd2, 8'h54); wr(4'd8, 8'h5A);
        start_line(4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("t1_busy", 32'(busy1), 32'h1);
            chk("t1_ascii", 32'(asc1), 32'(exp_asc[i]));
            chk("t1_row", 32'(row1), 32'h0);
            step();
        end
        chk("t1_busy_last", 32'(busy1), 32'h1);
        step();
        chk("t1_busy_done", 32'(busy1), 32'h0);

        // Test 2: serialise the whole line; first 16 pulses also check hold
        for (int i = 0; i < 64; i++) begin
            pix_advance = 1'b1;
            step();
            pix_advance = 1'b0;
            chk("t2_pix", 32'(pix1), 32'(pix_exp(s1[i/8], 3'd0, i%8)));
            if (i < 16) begin
                step();
                chk("t2_hold", 32'(pix1), 32'(pix_exp(s1[i/8], 3'd0, i%8)));
            end
        end
        step();
        pix_advance = 1'b1;
        step();
        pix_advance = 1'b0;
        chk("t2_idle_pix", 32'(pix1), 32'h0);
        chk("t2_idle_und", 32'(und1), 32'h0);

        // Test 3: SCALE=2 instance, "1" row 6
        wr(4'd0, 8'h31);
        start_line(4'd6, 1'b1);
        repeat (9) step();
        pix_advance = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t3_pix", 32'(pix2), 32'(pix_exp(8'h31, 3'd6, i/2)));
        end
        pix_advance = 1'b0;

        // Test 4: blank row keeps duration, issues nothing, zero-fills
        start_line(4'd9, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk("t4_busy", 32'(busy1), 32'h1);
            chk("t4_ascii", 32'(asc1), 32'h20);
            chk("t4_row", 32'(row1), 32'h6);
            step();
        end
        chk("t4_busy_done", 32'(busy1), 32'h0);
        pix_advance = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step();
            chk("t4_pix", 32'(pix1), 32'h0);
        end
        pix_advance = 1'b0;

        // Test 6a: abort in SHIFT with simultaneous pix_advance
        wr(4'd0, 8'h42);
        start_line(4'd0, 1'b1);
        repeat (9) step();
        pix_advance = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_pre_pix", 32'(pix1), 32'h1);
        end
        line_start = 1'b1; y_row = 4'd3; active_line = 1'b1;
        step();
        line_start = 1'b0; pix_advance = 1'b0;
        chk("t6_drop_pix", 32'(pix1), 32'h0);
        chk("t6_no_und1", 32'(und1), 32'h0);
        chk("t6_no_und2", 32'(und2), 32'h0);
        chk("t6_busy", 32'(busy1), 32'h1);
        chk("t6_ascii", 32'(asc1), 32'h42);
        chk("t6_row", 32'(row1), 32'h3);
        repeat (9) step();
        pix_advance = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_row3_pix", 32'(pix1), 32'(pix_exp(8'h42, 3'd3, i)));
        end
        pix_advance = 1'b0;

        // Test 5: pix_advance during FETCH sets sticky underrun
        start_line(4'd0, 1'b1);
        pix_advance = 1'b1;
        step();
        pix_advance = 1'b0;
        chk("t5_pix", 32'(pix1), 32'h0);
        chk("t5_und1", 32'(und1), 32'h1);
        chk("t5_und2", 32'(und2), 32'h1);
        repeat (10) step();
        start_line(4'd0, 1'b0);
        chk("t5_idle_busy", 32'(busy1), 32'h0);
        chk("t5_und_sticky", 32'(und1), 32'h1);
        start_line(4'd2, 1'b1);
        repeat (10) step();
        chk("t5_und_later", 32'(und1), 32'h1);
        chk("t5_busy_later", 32'(busy1), 32'h0);

        // Test 6b: reset mid-FETCH
        start_line(4'd0, 1'b1);
        step();
        chk("t6b_busy_pre", 32'(busy1), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) s1[i] = 8'h20;
        chk("t6b_busy", 32'(busy1), 32'h0);
        chk("t6b_ascii", 32'(asc1), 32'h20);
        chk("t6b_row", 32'(row1), 32'h0);
        chk("t6b_und", 32'(und1), 32'h0);
        chk("t6b_pix", 32'(pix1), 32'h0);
        start_line(4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("t6b_str_ascii", 32'(asc1), 32'h20);
            step();
        end
        step();
        pix_advance = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6b_pix_blank", 32'(pix1), 32'h0);
        end
        pix_advance = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
